// File: rtl/pspin_hostmem_ar_splitter_if.sv
// rtl/pspin_hostmem_ar_splitter_if.sv - AXI4 read-channel bundle (AR + R) shared by the splitter's two sides
interface pspin_hostmem_ar_splitter_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 8
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/pspin_hostmem_ar_splitter.sv
// rtl/pspin_hostmem_ar_splitter.sv - splits INCR read bursts at BOUNDARY / MAX_BURST_BEATS and re-merges R
// A small flag FIFO remembers which sub-burst ends the original burst so only that rlast goes upstream.
module pspin_hostmem_ar_splitter #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int ID_WIDTH        = 8,
   parameter int BOUNDARY        = 4096,
   parameter int MAX_BURST_BEATS = 256,
   parameter int OUTSTANDING     = 16
) (
   input logic                         clk,
   input logic                         rstn,
   pspin_hostmem_ar_splitter_if.slave  s_axi,
   pspin_hostmem_ar_splitter_if.master m_axi
);
   localparam int BW = $clog2(BOUNDARY);
   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = (BW + 1 > 9) ? BW + 1 : 9;

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t                state_q, state_d;
   logic                  arready_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [8:0]            rem_q;
   logic                  first_q;

   logic [ADDR_WIDTH-1:0] align_mask, a_addr, next_addr;
   logic [BW:0]           to_bnd;
   logic [CW-1:0]         rem_w, bnd_w, cap_w, n_w;
   logic [8:0]            n_beats;
   logic                  last_flag, ar_hs, push, pop;

   logic [OUTSTANDING-1:0] flag_mem;
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [PW:0]            count;
   logic                   full, empty, head;
   logic [DATA_WIDTH-1:0]  rdata;

   // Sub-burst sizing: beats left before the boundary, capped by remaining beats and the burst cap
   always_comb begin
      align_mask = ~((ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1));
      a_addr     = addr_q & align_mask;
      to_bnd     = ((BW + 1)'(BOUNDARY) - {1'b0, a_addr[BW-1:0]}) >> size_q;
      rem_w      = CW'(rem_q);
      bnd_w      = CW'(to_bnd);
      cap_w      = CW'(MAX_BURST_BEATS);
      n_w        = rem_w;
      if (burst_q == 2'b01) begin
         if (bnd_w < n_w) n_w = bnd_w;
         if (cap_w < n_w) n_w = cap_w;
      end
      n_beats    = n_w[8:0];
      last_flag  = (n_beats == rem_q);
      next_addr  = a_addr + (ADDR_WIDTH'(n_beats) << size_q);
   end

   assign full  = (count == (PW + 1)'(OUTSTANDING));
   assign empty = (count == '0);
   assign head  = flag_mem[rd_ptr];

   assign ar_hs = s_axi.arvalid & arready_q;
   assign push  = m_axi.arvalid & m_axi.arready;
   assign pop   = m_axi.rvalid & m_axi.rready & m_axi.rlast & ~empty;

   assign s_axi.arready = arready_q;
   assign m_axi.arvalid = (state_q == SPLIT) & ~full;
   assign m_axi.arid    = id_q;
   assign m_axi.araddr  = first_q ? addr_q : a_addr;
   assign m_axi.arlen   = 8'(n_beats - 9'd1);
   assign m_axi.arsize  = size_q;
   assign m_axi.arburst = burst_q;

   assign rdata         = m_axi.rdata;
   assign s_axi.rdata   = rdata;
   assign s_axi.rid     = m_axi.rid;
   assign s_axi.rresp   = m_axi.rresp;
   assign s_axi.rvalid  = m_axi.rvalid;
   assign s_axi.rlast   = m_axi.rlast & (empty | head);
   assign m_axi.rready  = s_axi.rready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ar_hs) state_d = SPLIT;
         SPLIT:   if (push && last_flag) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         arready_q <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         rem_q     <= '0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         arready_q <= (state_d == IDLE);
         if (state_q == IDLE && ar_hs) begin
            id_q    <= s_axi.arid;
            addr_q  <= s_axi.araddr;
            size_q  <= s_axi.arsize;
            burst_q <= s_axi.arburst;
            rem_q   <= {1'b0, s_axi.arlen} + 9'd1;
            first_q <= 1'b1;
         end else if (state_q == SPLIT && push) begin
            addr_q  <= next_addr;
            rem_q   <= rem_q - n_beats;
            first_q <= 1'b0;
         end
      end
   end

   // Downstream answers in AR order, so a plain FIFO lines flags up with sub-bursts
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         flag_mem <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            flag_mem[wr_ptr] <= last_flag;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_pspin_hostmem_ar_splitter.sv
// tb/tb_pspin_hostmem_ar_splitter.sv - directed bench for the AR splitter (flag FIFO depth 2)
module tb_pspin_hostmem_ar_splitter;
   localparam int AW = 64;
   localparam int DW = 512;
   localparam int IW = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   pspin_hostmem_ar_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_if ();
   pspin_hostmem_ar_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_if ();

   pspin_hostmem_ar_splitter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
      .BOUNDARY(4096), .MAX_BURST_BEATS(256), .OUTSTANDING(2)
   ) dut (
      .clk   (clk),
      .rstn  (rstn),
      .s_axi (s_if),
      .m_axi (m_if)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [63:0] exp_addr [8];
   int          exp_len  [8];
   int          n_sub;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic issue_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      int t;
      @(negedge clk);
      s_if.arid    = id;
      s_if.araddr  = addr;
      s_if.arlen   = len;
      s_if.arsize  = size;
      s_if.arburst = burst;
      s_if.arvalid = 1'b1;
      t = 0;
      while (!s_if.arready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("s_arready", s_if.arready, 1);
      @(posedge clk);
      #1 s_if.arvalid = 1'b0;
   endtask

   task automatic take_ar(input int k, input logic [7:0] id, input logic [2:0] size, input logic [1:0] burst);
      @(negedge clk);
      check($sformatf("m_arvalid[%0d]", k), m_if.arvalid, 1);
      check($sformatf("m_araddr[%0d]", k), m_if.araddr, exp_addr[k]);
      check($sformatf("m_arlen[%0d]", k), m_if.arlen, 64'(exp_len[k]));
      check($sformatf("m_arid[%0d]", k), m_if.arid, id);
      check($sformatf("m_arsize[%0d]", k), m_if.arsize, size);
      check($sformatf("m_arburst[%0d]", k), m_if.arburst, burst);
      check($sformatf("s_arready_busy[%0d]", k), s_if.arready, 0);
      m_if.arready = 1'b1;
      @(posedge clk);
      #1 m_if.arready = 1'b0;
   endtask

   task automatic send_r(input int beats, input logic final_sub, input logic [7:0] id, input logic [1:0] resp);
      for (int b = 0; b < beats; b++) begin
         @(negedge clk);
         m_if.rvalid  = 1'b1;
         m_if.rlast   = (b == beats - 1);
         m_if.rdata   = DW'(b + 7);
         m_if.rid     = id;
         m_if.rresp   = resp;
         s_if.rready  = 1'b1;
         #1;
         check("s_rlast", s_if.rlast, (b == beats - 1) && final_sub);
         if (b == 0) begin
            check("s_rvalid", s_if.rvalid, 1);
            check("s_rdata", s_if.rdata[63:0], 64'(b + 7));
            check("s_rid", s_if.rid, id);
            check("s_rresp", s_if.rresp, resp);
            check("m_rready", m_if.rready, 1);
         end
         @(posedge clk);
      end
      #1;
      m_if.rvalid = 1'b0;
      m_if.rlast  = 1'b0;
   endtask

   task automatic run_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
      issue_ar(id, addr, len, size, burst);
      for (int k = 0; k < n_sub; k++) begin
         take_ar(k, id, size, burst);
         if (k == n_sub - 1) begin
            @(negedge clk);
            check("s_arready_back", s_if.arready, 1);
         end
         send_r(exp_len[k] + 1, k == n_sub - 1, id, 2'b00);
      end
   endtask

   task automatic set_exp(input int k, input logic [63:0] addr, input int len);
      exp_addr[k] = addr;
      exp_len[k]  = len;
   endtask

   initial begin
      s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
      s_if.arburst = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
      m_if.arready = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
      m_if.rlast = 1'b0; m_if.rvalid = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_s_arready", s_if.arready, 0);
      check("rst_m_arvalid", m_if.arvalid, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_s_arready", s_if.arready, 1);
      check("idle_m_arvalid", m_if.arvalid, 0);

      // aligned 64-beat burst: single sub-burst
      n_sub = 1; set_exp(0, 64'h1000, 63);
      run_burst(8'h11, 64'h1000, 8'd63, 3'd6, 2'b01);

      // crosses 4 KiB after one beat
      n_sub = 2; set_exp(0, 64'h0FC0, 0); set_exp(1, 64'h1000, 2);
      run_burst(8'h22, 64'h0FC0, 8'd3, 3'd6, 2'b01);

      // unaligned start keeps the original address on the first sub-burst only
      n_sub = 2; set_exp(0, 64'h0FC8, 0); set_exp(1, 64'h1000, 0);
      run_burst(8'h23, 64'h0FC8, 8'd1, 3'd6, 2'b01);

      // 16 KiB burst -> four 4 KiB pieces
      n_sub = 4;
      set_exp(0, 64'h0000, 63); set_exp(1, 64'h1000, 63);
      set_exp(2, 64'h2000, 63); set_exp(3, 64'h3000, 63);
      run_burst(8'h33, 64'h0, 8'd255, 3'd6, 2'b01);

      // 8-byte beats: 16 beats to the boundary, then 240
      n_sub = 2; set_exp(0, 64'h0F80, 15); set_exp(1, 64'h1000, 239);
      run_burst(8'h34, 64'h0F80, 8'd255, 3'd3, 2'b01);

      // WRAP is forwarded unsplit
      n_sub = 1; set_exp(0, 64'h0FC0, 3);
      run_burst(8'h44, 64'h0FC0, 8'd3, 3'd6, 2'b10);

      // back-pressure: two flags outstanding fill the FIFO
      set_exp(0, 64'h100, 0); set_exp(1, 64'h200, 0); set_exp(2, 64'h300, 0);
      issue_ar(8'h51, 64'h100, 8'd0, 3'd6, 2'b01);
      take_ar(0, 8'h51, 3'd6, 2'b01);
      issue_ar(8'h52, 64'h200, 8'd0, 3'd6, 2'b01);
      take_ar(1, 8'h52, 3'd6, 2'b01);
      issue_ar(8'h53, 64'h300, 8'd0, 3'd6, 2'b01);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_hold_arvalid", m_if.arvalid, 0);
      end
      @(negedge clk);
      m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rid = 8'h51; s_if.rready = 1'b1;
      #1;
      check("bp_rlast0", s_if.rlast, 1);
      check("bp_still_held", m_if.arvalid, 0);
      @(posedge clk);
      #1 m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
      take_ar(2, 8'h53, 3'd6, 2'b01);
      send_r(1, 1'b1, 8'h52, 2'b10);
      send_r(1, 1'b1, 8'h53, 2'b00);

      // reset while splitting: a non-final flag is pending when rstn drops
      set_exp(0, 64'h0, 63);
      issue_ar(8'h61, 64'h0, 8'd255, 3'd6, 2'b01);
      take_ar(0, 8'h61, 3'd6, 2'b01);
      @(negedge clk);
      check("pre_rst_arvalid", m_if.arvalid, 1);
      rstn = 1'b0;
      #1;
      check("rst_async_arvalid", m_if.arvalid, 0);
      check("rst_async_arready", s_if.arready, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_arready", s_if.arready, 1);
      check("post_rst_arvalid", m_if.arvalid, 0);
      m_if.rvalid = 1'b1; m_if.rlast = 1'b1; s_if.rready = 1'b1;
      #1;
      check("empty_fifo_rlast1", s_if.rlast, 1);
      @(posedge clk);
      #1 m_if.rlast = 1'b0;
      #1;
      check("empty_fifo_rlast0", s_if.rlast, 0);
      @(negedge clk);
      m_if.rvalid = 1'b0;

      n_sub = 2; set_exp(0, 64'h0FC0, 0); set_exp(1, 64'h1000, 2);
      run_burst(8'h71, 64'h0FC0, 8'd3, 3'd6, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
